// File: rtl/sell_irq_sequencer.sv
// Services four edge-capture PIO slaves round-robin and queues {source, level}
// events in a small FIFO with a sticky overflow flag.
module sell_irq_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] src_en,
  input  logic [3:0] irq,
  output logic [3:0] m_chipselect,
  output logic [1:0] m_address,
  output logic       m_write_n,
  output logic       m_writedata,
  input  logic [3:0] m_readdata,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_src,
  output logic       evt_level,
  output logic [3:0] fifo_count,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {CFG, IDLE, RD_EC, WAIT_EC, CLR, RD_DAT, WAIT_DAT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      cfg_idx_q, cfg_idx_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      last_grant_q, last_grant_d;
  logic [2:0]      mem_q [FIFO_DEPTH];
  logic [2:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [3:0]      count_q, count_d;
  logic            overflow_q, overflow_d;

  logic [3:0] pending, grant_oh, cs_c;
  logic [1:0] addr_c, pick, cand;
  logic       wn_c, wd_c, found, push, pop, full, push_ok, drop;

  assign pending  = irq & src_en;
  assign grant_oh = 4'b0001 << grant_q;

  always_comb begin
    state_d      = state_q;
    cfg_idx_d    = cfg_idx_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    push         = 1'b0;
    cs_c         = 4'b0000;
    addr_c       = 2'd0;
    wn_c         = 1'b1;
    wd_c         = 1'b0;
    found        = 1'b0;
    pick         = last_grant_q;
    cand         = last_grant_q;

    // Search begins one past the last grant so every source gets a turn.
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant_q + 2'(i);
      if (!found && pending[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end

    case (state_q)
      CFG: begin
        cs_c      = 4'b0001 << cfg_idx_q;
        addr_c    = 2'd2;
        wn_c      = 1'b0;
        wd_c      = 1'b1;
        cfg_idx_d = cfg_idx_q + 2'd1;
        if (cfg_idx_q == 2'd3) state_d = IDLE;
      end
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = RD_EC;
        end
      end
      RD_EC: begin
        cs_c    = grant_oh;
        addr_c  = 2'd3;
        state_d = WAIT_EC;
      end
      WAIT_EC: begin
        last_grant_d = grant_q;
        state_d      = m_readdata[grant_q] ? CLR : IDLE;
      end
      CLR: begin
        cs_c    = grant_oh;
        addr_c  = 2'd3;
        wn_c    = 1'b0;
        state_d = RD_DAT;
      end
      RD_DAT: begin
        cs_c    = grant_oh;
        addr_c  = 2'd0;
        state_d = WAIT_DAT;
      end
      WAIT_DAT: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = CFG;
    endcase

    // Bus stays quiet for the whole reset assertion, not just after the edge.
    if (reset) begin
      cs_c   = 4'b0000;
      addr_c = 2'd0;
      wn_c   = 1'b1;
      wd_c   = 1'b0;
    end
  end

  assign m_chipselect = cs_c;
  assign m_address    = addr_c;
  assign m_write_n    = wn_c;
  assign m_writedata  = wd_c;

  assign evt_valid  = (count_q != 4'd0);
  assign full       = (count_q == 4'(FIFO_DEPTH));
  assign pop        = evt_valid && evt_ready;
  assign push_ok    = push && (!full || pop);
  assign drop       = push && full && !pop;
  assign evt_src    = evt_valid ? mem_q[rd_ptr_q][2:1] : 2'd0;
  assign evt_level  = evt_valid ? mem_q[rd_ptr_q][0] : 1'b0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {grant_q, m_readdata[grant_q]};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    // A drop wins over a simultaneous clear so no loss goes unreported.
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CFG;
      cfg_idx_q    <= 2'd0;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= 4'd0;
      overflow_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 3'd0;
    end else begin
      state_q      <= state_d;
      cfg_idx_q    <= cfg_idx_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      mem_q        <= mem_d;
    end
  end

endmodule

// File: tb/tb_sell_irq_sequencer.sv
// Bench for sell_irq_sequencer: behavioural PIO slaves plus an event-level
// reference model (round-robin order, FIFO queue, overflow rules).
module tb_sell_irq_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] src_en, irq, m_chipselect, m_readdata, fifo_count;
  logic [1:0] m_address, evt_src;
  logic       m_write_n, m_writedata, evt_valid, evt_ready, evt_level, overflow, ovf_clr;

  logic [3:0] ec, mask, pin, rd, ec_set, ec_kill, irq_extra, clr_now;

  int n_pass = 0;
  int n_total = 0;

  sell_irq_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .src_en(src_en), .irq(irq),
    .m_chipselect(m_chipselect), .m_address(m_address), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_src(evt_src),
    .evt_level(evt_level), .fifo_count(fifo_count), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Four edge-capture PIO slaves with registered readdata.
  assign irq        = (ec & mask) | irq_extra;
  assign m_readdata = rd;

  always_comb begin
    clr_now = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (m_chipselect[i] && !m_write_n && m_address == 2'd3) clr_now[i] = 1'b1;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (m_chipselect[i]) begin
        if (!m_write_n && m_address == 2'd2) mask[i] <= m_writedata;
        case (m_address)
          2'd0:    rd[i] <= pin[i];
          2'd2:    rd[i] <= mask[i];
          2'd3:    rd[i] <= ec[i];
          default: rd[i] <= 1'b0;
        endcase
      end else begin
        rd[i] <= 1'b0;
      end
    end
    ec <= (ec & ~clr_now & ~ec_kill) | ec_set;
  end

  task automatic raise_ec(input logic [3:0] v);
    @(negedge clk) ec_set = v;
    @(negedge clk) ec_set = 4'b0000;
  endtask

  task automatic reset_and_cfg();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // One isolated service of source s; optional pop and/or ovf_clr in its push cycle.
  task automatic one_event(input int s, input logic lvl, input logic rdy5, input logic clr5);
    pin[s] = lvl;
    raise_ec(4'(1 << s));
    repeat (5) @(negedge clk);
    evt_ready = rdy5;
    ovf_clr   = clr5;
    @(negedge clk);
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; src_en = 4'hF; irq_extra = 4'h0; ec_set = 4'h0; ec_kill = 4'hF;
    pin = 4'h0; evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    ec_kill = 4'h0;
    n_total++;
    if ({m_chipselect, m_address, m_write_n, m_writedata} !== 8'b0000_00_1_0)
      $display("FAIL reset_bus: got cs=%b addr=%0d wn=%b wd=%b want cs=0000 addr=0 wn=1 wd=0",
               m_chipselect, m_address, m_write_n, m_writedata);
    else n_pass++;
    n_total++;
    if ({evt_valid, evt_src, evt_level} !== 4'b0)
      $display("FAIL reset_evt: got valid=%b src=%0d lvl=%b want 0", evt_valid, evt_src, evt_level);
    else n_pass++;
    n_total++;
    if (fifo_count !== 4'd0 || overflow !== 1'b0)
      $display("FAIL reset_fifo: got count=%0d ovf=%b want 0/0", fifo_count, overflow);
    else n_pass++;
  endtask

  task automatic test_cfg();
    @(negedge clk) reset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      n_total++;
      if (m_chipselect !== 4'(1 << k) || m_address !== 2'd2 || m_write_n !== 1'b0 || m_writedata !== 1'b1)
        $display("FAIL cfg_cycle%0d: got cs=%b addr=%0d wn=%b wd=%b want cs=%b addr=2 wn=0 wd=1",
                 k, m_chipselect, m_address, m_write_n, m_writedata, 4'(1 << k));
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (m_chipselect !== 4'b0 || m_write_n !== 1'b1 || m_writedata !== 1'b0 || mask !== 4'hF)
      $display("FAIL cfg_idle: got cs=%b wn=%b wd=%b masks=%b want 0000/1/0/1111",
               m_chipselect, m_write_n, m_writedata, mask);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [3:0] exp_cs [6] = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    logic [1:0] exp_ad [6] = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd0};
    logic       exp_wn [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    pin = 4'b0001; src_en = 4'hF; evt_ready = 1'b0;
    raise_ec(4'b0001);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      n_total++;
      if (m_chipselect !== exp_cs[c] || m_write_n !== exp_wn[c] || m_writedata !== 1'b0 ||
          (exp_cs[c] != 4'b0 && m_address !== exp_ad[c]) || evt_valid !== 1'b0)
        $display("FAIL single_cycle%0d: got cs=%b addr=%0d wn=%b wd=%b v=%b want cs=%b addr=%0d wn=%b wd=0 v=0",
                 c, m_chipselect, m_address, m_write_n, m_writedata, evt_valid, exp_cs[c], exp_ad[c], exp_wn[c]);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (evt_valid !== 1'b1 || evt_src !== 2'd0 || evt_level !== 1'b1 || fifo_count !== 4'd1)
      $display("FAIL single_event: got v=%b src=%0d lvl=%b cnt=%0d want 1/0/1/1",
               evt_valid, evt_src, evt_level, fifo_count);
    else n_pass++;
    evt_ready = 1'b1;
    @(negedge clk) evt_ready = 1'b0;
    n_total++;
    if (fifo_count !== 4'd0 || evt_valid !== 1'b0)
      $display("FAIL single_pop: got cnt=%0d v=%b want 0/0", fifo_count, evt_valid);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int times[$];
    logic [3:0] prev;
    reset_and_cfg();
    pin = 4'($urandom);
    evt_ready = 1'b0;
    raise_ec(4'hF);
    prev = fifo_count;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (fifo_count != prev) begin
        times.push_back(t);
        prev = fifo_count;
      end
    end
    n_total++;
    if (times.size() != 4 || times[0] != 6 || times[1] != 12 || times[2] != 18 || times[3] != 24)
      $display("FAIL rr_spacing: got %0d pushes first at cycle %0d want 4 pushes at 6,12,18,24",
               times.size(), (times.size() > 0) ? times[0] : -1);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (evt_valid !== 1'b1 || evt_src !== 2'(k) || evt_level !== pin[k])
        $display("FAIL rr_order%0d: got v=%b src=%0d lvl=%b want 1/%0d/%b",
                 k, evt_valid, evt_src, evt_level, k, pin[k]);
      else n_pass++;
      evt_ready = 1'b1;
      @(negedge clk) evt_ready = 1'b0;
    end
  endtask

  task automatic test_spurious();
    logic bad;
    int order[3] = '{3, 0, 1};
    @(negedge clk) irq_extra = 4'b0100;
    @(negedge clk);
    n_total++;
    if (m_chipselect !== 4'b0100 || m_address !== 2'd3 || m_write_n !== 1'b1)
      $display("FAIL spur_rd_ec: got cs=%b addr=%0d wn=%b want 0100/3/1", m_chipselect, m_address, m_write_n);
    else n_pass++;
    @(negedge clk) irq_extra = 4'b0000;
    bad = (m_chipselect !== 4'b0);
    for (int c = 3; c <= 8; c++) begin
      @(negedge clk);
      if (m_chipselect !== 4'b0 || m_write_n !== 1'b1) bad = 1'b1;
    end
    n_total++;
    if (bad !== 1'b0 || fifo_count !== 4'd0)
      $display("FAIL spur_no_clr: got bus_activity=%b cnt=%0d want 0/0", bad, fifo_count);
    else n_pass++;
    // Last grant is now 2, so sources 0,1,3 are served as 3,0,1.
    pin = 4'b1010;
    raise_ec(4'b1011);
    repeat (24) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (evt_valid !== 1'b1 || evt_src !== 2'(order[k]) || evt_level !== pin[order[k]])
        $display("FAIL spur_next%0d: got v=%b src=%0d lvl=%b want 1/%0d/%b",
                 k, evt_valid, evt_src, evt_level, order[k], pin[order[k]]);
      else n_pass++;
      evt_ready = 1'b1;
      @(negedge clk) evt_ready = 1'b0;
    end
  endtask

  task automatic test_overflow();
    logic [2:0] q[$];
    int   srcs[7] = '{0, 1, 2, 3, 0, 1, 2};
    logic lvls[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    evt_ready = 1'b0;
    for (int e = 0; e < 5; e++) begin
      one_event(srcs[e], lvls[e], 1'b0, 1'b0);
      if (q.size() < 4) q.push_back({2'(srcs[e]), lvls[e]});
    end
    n_total++;
    if (fifo_count !== 4'd4 || overflow !== 1'b1)
      $display("FAIL ovf_fill: got cnt=%0d ovf=%b want 4/1", fifo_count, overflow);
    else n_pass++;
    @(negedge clk) ovf_clr = 1'b1;
    @(negedge clk) ovf_clr = 1'b0;
    n_total++;
    if (overflow !== 1'b0)
      $display("FAIL ovf_clear: got ovf=%b want 0", overflow);
    else n_pass++;
    one_event(srcs[5], lvls[5], 1'b1, 1'b0);
    void'(q.pop_front());
    q.push_back({2'(srcs[5]), lvls[5]});
    n_total++;
    if (fifo_count !== 4'd4 || overflow !== 1'b0)
      $display("FAIL ovf_push_pop_full: got cnt=%0d ovf=%b want 4/0", fifo_count, overflow);
    else n_pass++;
    one_event(srcs[6], lvls[6], 1'b0, 1'b1);
    n_total++;
    if (fifo_count !== 4'd4 || overflow !== 1'b1)
      $display("FAIL ovf_drop_beats_clr: got cnt=%0d ovf=%b want 4/1", fifo_count, overflow);
    else n_pass++;
    @(negedge clk) ovf_clr = 1'b1;
    @(negedge clk) ovf_clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (evt_valid !== 1'b1 || {evt_src, evt_level} !== q[k])
        $display("FAIL ovf_contents%0d: got v=%b src=%0d lvl=%b want 1/%0d/%b",
                 k, evt_valid, evt_src, evt_level, q[k][2:1], q[k][0]);
      else n_pass++;
      evt_ready = 1'b1;
      @(negedge clk) evt_ready = 1'b0;
    end
    n_total++;
    if (fifo_count !== 4'd0 || overflow !== 1'b0)
      $display("FAIL ovf_drained: got cnt=%0d ovf=%b want 0/0", fifo_count, overflow);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    pin[1] = 1'b1;
    raise_ec(4'b0010);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    n_total++;
    if (m_chipselect !== 4'b0 || m_write_n !== 1'b1 || m_writedata !== 1'b0 || m_address !== 2'd0 ||
        evt_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0)
      $display("FAIL midrst_outputs: got cs=%b addr=%0d wn=%b wd=%b v=%b cnt=%0d ovf=%b want reset values",
               m_chipselect, m_address, m_write_n, m_writedata, evt_valid, fifo_count, overflow);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n_total++;
    if (m_chipselect !== 4'b0001 || m_address !== 2'd2 || m_write_n !== 1'b0 || m_writedata !== 1'b1 ||
        fifo_count !== 4'd0)
      $display("FAIL midrst_cfg_restart: got cs=%b addr=%0d wn=%b wd=%b cnt=%0d want 0001/2/0/1/0",
               m_chipselect, m_address, m_write_n, m_writedata, fifo_count);
    else n_pass++;
    // The aborted clear left edge_capture[1] set, so it is serviced again after CFG.
    repeat (12) @(negedge clk);
    n_total++;
    if (evt_valid !== 1'b1 || evt_src !== 2'd1 || evt_level !== 1'b1 || fifo_count !== 4'd1)
      $display("FAIL midrst_reservice: got v=%b src=%0d lvl=%b cnt=%0d want 1/1/1/1",
               evt_valid, evt_src, evt_level, fifo_count);
    else n_pass++;
    evt_ready = 1'b1;
    @(negedge clk) evt_ready = 1'b0;
  endtask

  task automatic test_random();
    int last;
    logic [3:0] e_v, en_v;
    logic [2:0] exp_q[$];
    reset_and_cfg();
    last = 3;
    for (int r = 0; r < 20; r++) begin
      e_v  = 4'($urandom_range(1, 15));
      en_v = 4'($urandom);
      @(negedge clk);
      src_en = en_v;
      pin    = 4'($urandom);
      exp_q  = {};
      for (int k = 1; k <= 4; k++) begin
        int s;
        s = (last + k) % 4;
        if (e_v[s] && en_v[s]) exp_q.push_back({2'(s), pin[s]});
      end
      raise_ec(e_v);
      repeat (30) @(negedge clk);
      n_total++;
      if (fifo_count !== 4'(exp_q.size()))
        $display("FAIL rand%0d_count: got cnt=%0d want %0d (ec=%b en=%b)", r, fifo_count, exp_q.size(), e_v, en_v);
      else n_pass++;
      for (int k = 0; k < exp_q.size(); k++) begin
        n_total++;
        if (evt_valid !== 1'b1 || {evt_src, evt_level} !== exp_q[k])
          $display("FAIL rand%0d_evt%0d: got v=%b src=%0d lvl=%b want 1/%0d/%b",
                   r, k, evt_valid, evt_src, evt_level, exp_q[k][2:1], exp_q[k][0]);
        else n_pass++;
        evt_ready = 1'b1;
        @(negedge clk) evt_ready = 1'b0;
      end
      if (exp_q.size() > 0) last = int'(exp_q[exp_q.size()-1][2:1]);
      @(negedge clk) ec_kill = 4'hF;
      @(negedge clk) ec_kill = 4'h0;
      while (fifo_count != 4'd0 && evt_valid) begin
        evt_ready = 1'b1;
        @(negedge clk) evt_ready = 1'b0;
      end
    end
    src_en = 4'hF;
  endtask

  initial begin
    test_reset();
    test_cfg();
    test_single();
    test_round_robin();
    test_spurious();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
